rv_exec_core: RTL and testbench



---
 rtl/rv_exec_pkg.sv | 38 +++
 rtl/rv_exec_alu.sv | 36 +++
 rtl/rv_exec_core.sv | 186 ++++++++++++++++++
 tb/tb_rv_exec_core.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/rv_exec_pkg.sv
// Shared encodings for the execute core: opcodes, funct3 values, ALU ops and FSM states.
package rv_exec_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
        ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
    } alu_op_t;

    typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

    // Base operation selected by funct3 alone; SUB/SRA come from funct7 at the call site.
    function automatic alu_op_t f3_to_op(input logic [2:0] f3);
        case (f3)
            F3_ADD:  return ALU_ADD;
            F3_SLL:  return ALU_SLL;
            F3_SLT:  return ALU_SLT;
            F3_SLTU: return ALU_SLTU;
            F3_XOR:  return ALU_XOR;
            F3_SR:   return ALU_SRL;
            F3_OR:   return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

endpackage

// File: rtl/rv_exec_alu.sv
// Combinational integer ALU, zero latency, no flow control.
module rv_exec_alu
    import rv_exec_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  alu_op_t           op,
    input  logic [XLEN-1:0]   a,
    input  logic [XLEN-1:0]   b,
    output logic [XLEN-1:0]   result
);

    localparam int SHW = $clog2(XLEN);

    logic [SHW-1:0] shamt;
    assign shamt = b[SHW-1:0];

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_SLL:   result = a << shamt;
            ALU_SLT:   result = XLEN'($signed(a) < $signed(b));
            ALU_SLTU:  result = XLEN'(a < b);
            ALU_XOR:   result = a ^ b;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_OR:    result = a | b;
            ALU_AND:   result = a & b;
            ALU_PASSB: result = b;
            default:   result = '0;
        endcase
    end

endmodule

// File: rtl/rv_exec_core.sv
// Multi-cycle RV32I/RV64I ALU execute core: retire/illegal pulse 3 cycles after handshake, one instr per 4 cycles.
// instr_ready drops while an instruction is in flight. Optional RV_EXEC_PERF_CNT_EN adds retired_count.
module rv_exec_core
    import rv_exec_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int NREGS = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              retire_valid,
    output logic [4:0]        retire_rd,
    output logic [XLEN-1:0]   retire_data,
    output logic              illegal,
    input  logic [4:0]        dbg_addr,
    output logic [XLEN-1:0]   dbg_data
`ifdef RV_EXEC_PERF_CNT_EN
    ,
    output logic [63:0]       retired_count
`endif
);

    localparam int IW = $clog2(NREGS);

    state_t            state;
    logic [31:0]       instr_q;
    logic [XLEN-1:0]   a_q, b_q, res_q;
    alu_op_t           op_q;
    logic [4:0]        rd_q;
    logic              dec_ok_q, ok_q;
    logic [XLEN-1:0]   regs [NREGS];
    logic [XLEN-1:0]   alu_res;

    function automatic logic idx_ok(input logic [4:0] idx);
        return 32'(idx) < NREGS;
    endfunction

    // x0 and indices beyond the implemented file both read as zero.
    function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
        if (idx == 5'd0 || !idx_ok(idx))
            return '0;
        return regs[idx[IW-1:0]];
    endfunction

    logic [6:0] f_opc, f_f7;
    logic [4:0] f_rd, f_rs1, f_rs2;
    logic [2:0] f_f3;
    assign f_opc = instr_q[6:0];
    assign f_rd  = instr_q[11:7];
    assign f_f3  = instr_q[14:12];
    assign f_rs1 = instr_q[19:15];
    assign f_rs2 = instr_q[24:20];
    assign f_f7  = instr_q[31:25];

    logic [XLEN-1:0] imm_i, imm_u;
    assign imm_i = XLEN'($signed(instr_q[31:20]));
    assign imm_u = XLEN'($signed({instr_q[31:12], 12'b0}));

    // Immediate shifts: upper field above the shamt is imm[11:5] or imm[11:6] depending on XLEN.
    logic sh_zero, sh_arith;
    assign sh_zero  = (XLEN == 64) ? (instr_q[31:26] == 6'b0)      : (instr_q[31:25] == 7'b0);
    assign sh_arith = (XLEN == 64) ? (instr_q[31:26] == 6'b010000) : (instr_q[31:25] == 7'b0100000);

    alu_op_t         dec_op;
    logic            dec_legal;
    logic [XLEN-1:0] dec_a, dec_b;

    always_comb begin
        dec_op    = ALU_ADD;
        dec_legal = 1'b0;
        dec_a     = rf_read(f_rs1);
        dec_b     = rf_read(f_rs2);
        case (f_opc)
            OPC_OP: begin
                dec_legal = idx_ok(f_rs1) && idx_ok(f_rs2) && idx_ok(f_rd);
                if (f_f7 == 7'b0000000)
                    dec_op = f3_to_op(f_f3);
                else if (f_f7 == 7'b0100000 && f_f3 == F3_ADD)
                    dec_op = ALU_SUB;
                else if (f_f7 == 7'b0100000 && f_f3 == F3_SR)
                    dec_op = ALU_SRA;
                else
                    dec_legal = 1'b0;
            end
            OPC_OP_IMM: begin
                dec_b     = imm_i;
                dec_legal = idx_ok(f_rs1) && idx_ok(f_rd);
                dec_op    = f3_to_op(f_f3);
                if (f_f3 == F3_SLL && !sh_zero)
                    dec_legal = 1'b0;
                if (f_f3 == F3_SR) begin
                    if (sh_arith)
                        dec_op = ALU_SRA;
                    else if (!sh_zero)
                        dec_legal = 1'b0;
                end
            end
            OPC_LUI: begin
                dec_a     = '0;
                dec_b     = imm_u;
                dec_op    = ALU_PASSB;
                dec_legal = idx_ok(f_rd);
            end
            default: dec_legal = 1'b0;
        endcase
    end

    rv_exec_alu #(.XLEN(XLEN)) u_alu (
        .op     (op_q),
        .a      (a_q),
        .b      (b_q),
        .result (alu_res)
    );

    always_comb dbg_data = rf_read(dbg_addr);

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            instr_ready  <= 1'b1;
            retire_valid <= 1'b0;
            illegal      <= 1'b0;
            retire_rd    <= '0;
            retire_data  <= '0;
            instr_q      <= '0;
            a_q          <= '0;
            b_q          <= '0;
            op_q         <= ALU_ADD;
            rd_q         <= '0;
            dec_ok_q     <= 1'b0;
            res_q        <= '0;
            ok_q         <= 1'b0;
            for (int i = 0; i < NREGS; i++)
                regs[i] <= '0;
`ifdef RV_EXEC_PERF_CNT_EN
            retired_count <= '0;
`endif
        end else begin
            retire_valid <= 1'b0;
            illegal      <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_valid && instr_ready) begin
                        instr_q     <= instr;
                        instr_ready <= 1'b0;
                        state       <= DECODE;
                    end
                end
                DECODE: begin
                    a_q      <= dec_a;
                    b_q      <= dec_b;
                    op_q     <= dec_op;
                    rd_q     <= f_rd;
                    dec_ok_q <= dec_legal;
                    state    <= EXEC;
                end
                EXEC: begin
                    // Pulses are registered here so they are visible throughout the WB cycle.
                    res_q        <= alu_res;
                    ok_q         <= dec_ok_q;
                    retire_valid <= dec_ok_q;
                    illegal      <= !dec_ok_q;
                    if (dec_ok_q) begin
                        retire_rd   <= rd_q;
                        retire_data <= alu_res;
`ifdef RV_EXEC_PERF_CNT_EN
                        retired_count <= retired_count + 64'd1;
`endif
                    end
                    state <= WB;
                end
                WB: begin
                    if (ok_q && rd_q != 5'd0)
                        regs[rd_q[IW-1:0]] <= res_q;
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rv_exec_core.sv
// Directed bench for rv_exec_core: default, NREGS=16 and XLEN=64 instances share one stimulus path.
module tb_rv_exec_core;

    logic        clock = 1'b0;
    logic        reset;
    logic        vld;
    logic [31:0] instr;
    logic [4:0]  dbg_addr;
    int          sel;
    int          errors = 0;
    int          checks = 0;

    always #5 clock = ~clock;

    logic        rdy0, rv0, il0, rdy1, rv1, il1, rdy2, rv2, il2;
    logic [4:0]  rrd0, rrd1, rrd2;
    logic [31:0] rdat0, dbg0, rdat1, dbg1;
    logic [63:0] rdat2, dbg2;
`ifdef RV_EXEC_PERF_CNT_EN
    logic [63:0] cnt0, cnt1, cnt2;
`endif

    rv_exec_core #(.XLEN(32), .NREGS(32)) dut (
        .clock(clock), .reset(reset), .instr_valid(vld && (sel == 0)), .instr_ready(rdy0),
        .instr(instr), .retire_valid(rv0), .retire_rd(rrd0), .retire_data(rdat0),
        .illegal(il0), .dbg_addr(dbg_addr), .dbg_data(dbg0)
`ifdef RV_EXEC_PERF_CNT_EN
        , .retired_count(cnt0)
`endif
    );

    rv_exec_core #(.XLEN(32), .NREGS(16)) dut_n16 (
        .clock(clock), .reset(reset), .instr_valid(vld && (sel == 1)), .instr_ready(rdy1),
        .instr(instr), .retire_valid(rv1), .retire_rd(rrd1), .retire_data(rdat1),
        .illegal(il1), .dbg_addr(dbg_addr), .dbg_data(dbg1)
`ifdef RV_EXEC_PERF_CNT_EN
        , .retired_count(cnt1)
`endif
    );

    rv_exec_core #(.XLEN(64), .NREGS(32)) dut_x64 (
        .clock(clock), .reset(reset), .instr_valid(vld && (sel == 2)), .instr_ready(rdy2),
        .instr(instr), .retire_valid(rv2), .retire_rd(rrd2), .retire_data(rdat2),
        .illegal(il2), .dbg_addr(dbg_addr), .dbg_data(dbg2)
`ifdef RV_EXEC_PERF_CNT_EN
        , .retired_count(cnt2)
`endif
    );

    logic        m_rdy, m_rv, m_il;
    logic [4:0]  m_rrd;
    logic [63:0] m_rdat, m_dbg;

    always_comb begin
        m_rdy = rdy0; m_rv = rv0; m_il = il0; m_rrd = rrd0;
        m_rdat = 64'(rdat0); m_dbg = 64'(dbg0);
        if (sel == 1) begin
            m_rdy = rdy1; m_rv = rv1; m_il = il1; m_rrd = rrd1;
            m_rdat = 64'(rdat1); m_dbg = 64'(dbg1);
        end else if (sel == 2) begin
            m_rdy = rdy2; m_rv = rv2; m_il = il2; m_rrd = rrd2;
            m_rdat = rdat2; m_dbg = dbg2;
        end
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Handshake one instruction, then watch the four following cycles for ready and pulse timing.
    task automatic do_instr(input string tag, input logic [31:0] w, input bit exp_ill,
                            input logic [4:0] exp_rd, input logic [63:0] exp_data);
        int n = 0;
        while (!m_rdy && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        if (!m_rdy) begin
            check({tag, "_ready_timeout"}, 64'(m_rdy), 64'd1);
            return;
        end
        instr = w;
        vld   = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin
                vld   = 1'b0;
                instr = $urandom;
            end
            check($sformatf("%s_ready_c%0d", tag, c), 64'(m_rdy), 64'(c == 4));
            check($sformatf("%s_pulse_c%0d", tag, c), 64'({m_rv, m_il}),
                  (c == 3) ? 64'({!exp_ill, exp_ill}) : 64'd0);
            if (c == 3 && !exp_ill) begin
                check({tag, "_rd"}, 64'(m_rrd), 64'(exp_rd));
                check({tag, "_data"}, m_rdat, exp_data);
            end
        end
    endtask

    task automatic check_reg(input string tag, input logic [4:0] idx, input logic [63:0] exp);
        dbg_addr = idx;
        #1;
        check(tag, m_dbg, exp);
        @(posedge clock); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; vld = 1'b0; instr = '0; dbg_addr = '0; sel = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        check("rst_ready", 64'(m_rdy), 64'd1);
        check("rst_pulses", 64'({m_rv, m_il}), 64'd0);
        check("rst_rd", 64'(m_rrd), 64'd0);
        check("rst_data", m_rdat, 64'd0);
        check_reg("rst_x1", 5'd1, 64'd0);

        do_instr("addi_x1", 32'h00500093, 1'b0, 5'd1, 64'd5);
        do_instr("addi_x2", 32'hFFD00113, 1'b0, 5'd2, 64'hFFFF_FFFD);
        do_instr("add_x3",  32'h002081B3, 1'b0, 5'd3, 64'd2);
        check_reg("reg_x3", 5'd3, 64'd2);

        do_instr("sub_x4",  32'h40208233, 1'b0, 5'd4, 64'd8);
        do_instr("srai_x5", 32'h40115293, 1'b0, 5'd5, 64'hFFFF_FFFE);
        do_instr("lui_x6",  32'h12345337, 1'b0, 5'd6, 64'h1234_5000);
        check_reg("reg_x4", 5'd4, 64'd8);
        check_reg("reg_x5", 5'd5, 64'hFFFF_FFFE);
        check_reg("reg_x6", 5'd6, 64'h1234_5000);

        do_instr("addi_x0", 32'h00700013, 1'b0, 5'd0, 64'd7);
        check_reg("reg_x0", 5'd0, 64'd0);

        do_instr("sltu_x9", 32'h001134B3, 1'b0, 5'd9, 64'd0);
        do_instr("slt_x10", 32'h00112533, 1'b0, 5'd10, 64'd1);
        check_reg("reg_x10", 5'd10, 64'd1);

        do_instr("ill_opc",  32'h0000007F, 1'b1, 5'd0, 64'd0);
        do_instr("ill_slli", 32'h02109413, 1'b1, 5'd0, 64'd0);
        check_reg("ill_x8", 5'd8, 64'd0);
        check_reg("ill_x1", 5'd1, 64'd5);
        check("ill_hold_rd", 64'(m_rrd), 64'd10);
`ifdef RV_EXEC_PERF_CNT_EN
        check("perf_count", cnt0, 64'd9);
`endif

        // Abort ADDI x7,x0,1 by asserting reset while it is in EXEC.
        instr = 32'h00100393;
        vld   = 1'b1;
        @(posedge clock); #1;
        vld = 1'b0;
        @(posedge clock); #1;
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        check("midrst_pulse0", 64'({m_rv, m_il}), 64'd0);
        check("midrst_ready0", 64'(m_rdy), 64'd1);
        @(posedge clock); #1;
        check("midrst_pulse1", 64'({m_rv, m_il}), 64'd0);
        check("midrst_ready1", 64'(m_rdy), 64'd1);
        check_reg("midrst_x7", 5'd7, 64'd0);
        check_reg("midrst_x1", 5'd1, 64'd0);
`ifdef RV_EXEC_PERF_CNT_EN
        check("midrst_count", cnt0, 64'd0);
`endif

        sel = 1;
        do_instr("n16_x15",  32'h00900793, 1'b0, 5'd15, 64'd9);
        do_instr("n16_rd16", 32'h00100813, 1'b1, 5'd0, 64'd0);
        do_instr("n16_rs16", 32'h00180093, 1'b1, 5'd0, 64'd0);
        check_reg("n16_x15_reg", 5'd15, 64'd9);
        check_reg("n16_x1_reg", 5'd1, 64'd0);
        check_reg("n16_dbg16", 5'd16, 64'd0);

        sel = 2;
        do_instr("x64_addi", 32'hFFF00093, 1'b0, 5'd1, 64'hFFFF_FFFF_FFFF_FFFF);
        do_instr("x64_srli", 32'h03F0D113, 1'b0, 5'd2, 64'd1);
        do_instr("x64_srai", 32'h43F0D193, 1'b0, 5'd3, 64'hFFFF_FFFF_FFFF_FFFF);
        do_instr("x64_lui",  32'h80000537, 1'b0, 5'd10, 64'hFFFF_FFFF_8000_0000);
        check_reg("x64_x2_reg", 5'd2, 64'd1);
        check_reg("x64_x10_reg", 5'd10, 64'hFFFF_FFFF_8000_0000);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
